// File: rtl/npu_stream_dma.sv
// -----------------------------------------------------------------------------
// npu_stream_dma
//
// Memory-side streaming DMA engine for the NPU. A read channel fetches 32-bit
// words over an Avalon-MM read master and presents them as a valid/ready
// stream toward the sequencer. A write channel accepts the sequencer's result
// stream and writes each word through an Avalon-MM write master. Both channels
// run concurrently under a single start/done handshake.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   start                   one-cycle job launch, ignored while busy
//   src_addr, dst_addr      base byte addresses (bits [1:0] ignored)
//   rd_words, wr_words      word counts per channel (0 = channel idle)
//   busy, done              job in progress / one-cycle completion pulse
//   avm_rd_*                Avalon-MM read master (pipelined, readdatavalid)
//   st_out_*                read data stream toward the sequencer
//   st_in_*                 result stream from the sequencer
//   avm_wr_*                Avalon-MM write master
// -----------------------------------------------------------------------------
module npu_stream_dma #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [31:0] rd_words,
    input  logic [31:0] wr_words,
    output logic        busy,
    output logic        done,
    output logic [31:0] avm_rd_address,
    output logic        avm_rd_read,
    input  logic        avm_rd_waitrequest,
    input  logic [31:0] avm_rd_readdata,
    input  logic        avm_rd_readdatavalid,
    output logic [31:0] st_out_data,
    output logic        st_out_valid,
    input  logic        st_out_ready,
    input  logic [31:0] st_in_data,
    input  logic        st_in_valid,
    output logic        st_in_ready,
    output logic [31:0] avm_wr_address,
    output logic        avm_wr_write,
    output logic [31:0] avm_wr_writedata,
    input  logic        avm_wr_waitrequest
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [FIFO_AW:0]   DEPTH_C      = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW+1:0] DEPTH_WIDE_C = (FIFO_AW+2)'(FIFO_DEPTH);

    state_t             state_r;
    logic               busy_r;
    logic               done_r;
    logic [31:0]        rd_addr_r;
    logic [31:0]        wr_addr_r;
    logic [31:0]        rd_words_r;
    logic [31:0]        wr_words_r;
    logic [31:0]        rd_issued_r;
    logic [31:0]        wr_accepted_r;
    logic [31:0]        wr_done_r;
    logic [FIFO_AW:0]   outstanding_r;
    logic [FIFO_AW:0]   fifo_count_r;
    logic [FIFO_AW-1:0] fifo_wr_ptr_r;
    logic [FIFO_AW-1:0] fifo_rd_ptr_r;
    logic [31:0]        fifo_mem_r [FIFO_DEPTH];
    logic               wr_pend_r;
    logic [31:0]        wr_data_r;

    logic               run_s;
    logic [FIFO_AW+1:0] used_s;
    logic               credit_ok_s;
    logic               rd_req_s;
    logic               rd_accept_s;
    logic               ret_valid_s;
    logic               fifo_empty_s;
    logic               fifo_full_s;
    logic               push_s;
    logic               pop_s;
    logic               in_ready_s;
    logic               in_accept_s;
    logic               wr_complete_s;
    logic               rd_side_done_s;
    logic               wr_side_done_s;

    assign run_s        = (state_r == ST_RUN);
    assign fifo_empty_s = (fifo_count_r == '0);
    assign fifo_full_s  = (fifo_count_r == DEPTH_C);

    // Buffered words plus in-flight reads may never exceed the FIFO size, so
    // every returned word is guaranteed a slot.
    assign used_s      = {1'b0, fifo_count_r} + {1'b0, outstanding_r};
    assign credit_ok_s = (used_s < DEPTH_WIDE_C);

    assign rd_req_s    = run_s && (rd_issued_r < rd_words_r) && credit_ok_s;
    assign rd_accept_s = rd_req_s && !avm_rd_waitrequest;

    // A return with nothing outstanding is a protocol error and is dropped.
    assign ret_valid_s = avm_rd_readdatavalid && (outstanding_r != '0);
    assign push_s      = ret_valid_s && !fifo_full_s;
    assign pop_s       = !fifo_empty_s && st_out_ready;

    assign in_ready_s     = run_s && !wr_pend_r && (wr_accepted_r < wr_words_r);
    assign in_accept_s    = in_ready_s && st_in_valid;
    assign wr_complete_s  = wr_pend_r && !avm_wr_waitrequest;

    assign rd_side_done_s = (rd_issued_r == rd_words_r) && (outstanding_r == '0) && fifo_empty_s;
    assign wr_side_done_s = (wr_done_r == wr_words_r) && !wr_pend_r;

    // All outputs are functions of registered state only.
    assign busy             = busy_r;
    assign done             = done_r;
    assign avm_rd_address   = rd_addr_r;
    assign avm_rd_read      = rd_req_s;
    assign st_out_valid     = !fifo_empty_s;
    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign st_out_data      = fifo_empty_s ? 32'h0000_0000 : fifo_mem_r[fifo_rd_ptr_r];
    assign st_in_ready      = in_ready_s;
    assign avm_wr_address   = wr_addr_r;
    assign avm_wr_write     = wr_pend_r;
    assign avm_wr_writedata = wr_data_r;

    // Job FSM, address/count bookkeeping and the write holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            rd_addr_r     <= 32'h0000_0000;
            wr_addr_r     <= 32'h0000_0000;
            rd_words_r    <= 32'h0000_0000;
            wr_words_r    <= 32'h0000_0000;
            rd_issued_r   <= 32'h0000_0000;
            wr_accepted_r <= 32'h0000_0000;
            wr_done_r     <= 32'h0000_0000;
            wr_pend_r     <= 1'b0;
            wr_data_r     <= 32'h0000_0000;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r       <= ST_RUN;
                        busy_r        <= 1'b1;
                        rd_addr_r     <= src_addr & 32'hFFFF_FFFC;
                        wr_addr_r     <= dst_addr & 32'hFFFF_FFFC;
                        rd_words_r    <= rd_words;
                        wr_words_r    <= wr_words;
                        rd_issued_r   <= 32'h0000_0000;
                        wr_accepted_r <= 32'h0000_0000;
                        wr_done_r     <= 32'h0000_0000;
                        wr_pend_r     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (rd_accept_s) begin
                        rd_issued_r <= rd_issued_r + 32'd1;
                        rd_addr_r   <= rd_addr_r + 32'd4;
                    end
                    // in_accept_s requires !wr_pend_r, so it never collides
                    // with a completion in the same cycle.
                    if (in_accept_s) begin
                        wr_data_r     <= st_in_data;
                        wr_pend_r     <= 1'b1;
                        wr_accepted_r <= wr_accepted_r + 32'd1;
                    end else if (wr_complete_s) begin
                        wr_pend_r <= 1'b0;
                        wr_done_r <= wr_done_r + 32'd1;
                        wr_addr_r <= wr_addr_r + 32'd4;
                    end
                    if (rd_side_done_s && wr_side_done_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // In-flight read counter: +1 per accepted request, -1 per valid return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_r <= '0;
        end else begin
            case ({rd_accept_s, ret_valid_s})
                2'b10:   outstanding_r <= outstanding_r + {{FIFO_AW{1'b0}}, 1'b1};
                2'b01:   outstanding_r <= outstanding_r - {{FIFO_AW{1'b0}}, 1'b1};
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Read-return FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_ptr_r <= '0;
            fifo_rd_ptr_r <= '0;
            fifo_count_r  <= '0;
        end else begin
            if (push_s) begin
                fifo_wr_ptr_r <= fifo_wr_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                fifo_rd_ptr_r <= fifo_rd_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + {{FIFO_AW{1'b0}}, 1'b1};
                2'b01:   fifo_count_r <= fifo_count_r - {{FIFO_AW{1'b0}}, 1'b1};
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // FIFO storage; contents are only observable through the masked head.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[fifo_wr_ptr_r] <= avm_rd_readdata;
        end
    end

endmodule

// File: tb/tb_npu_stream_dma.sv
// -----------------------------------------------------------------------------
// tb_npu_stream_dma
//
// Directed bench for npu_stream_dma. A single step task advances to the next
// falling edge, observes the DUT outputs and drives the memory slaves and the
// stream endpoints for the following rising edge, so everything runs in one
// process. Read memory returns addr ^ 32'hA5A5A5A5 after a set latency.
// -----------------------------------------------------------------------------
module tb_npu_stream_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] src_addr, dst_addr, rd_words, wr_words;
    logic        busy, done;
    logic [31:0] avm_rd_address;
    logic        avm_rd_read, avm_rd_waitrequest;
    logic [31:0] avm_rd_readdata;
    logic        avm_rd_readdatavalid;
    logic [31:0] st_out_data;
    logic        st_out_valid, st_out_ready;
    logic [31:0] st_in_data;
    logic        st_in_valid, st_in_ready;
    logic [31:0] avm_wr_address;
    logic        avm_wr_write;
    logic [31:0] avm_wr_writedata;
    logic        avm_wr_waitrequest;

    npu_stream_dma #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr),
        .rd_words(rd_words), .wr_words(wr_words),
        .busy(busy), .done(done),
        .avm_rd_address(avm_rd_address), .avm_rd_read(avm_rd_read),
        .avm_rd_waitrequest(avm_rd_waitrequest), .avm_rd_readdata(avm_rd_readdata),
        .avm_rd_readdatavalid(avm_rd_readdatavalid),
        .st_out_data(st_out_data), .st_out_valid(st_out_valid), .st_out_ready(st_out_ready),
        .st_in_data(st_in_data), .st_in_valid(st_in_valid), .st_in_ready(st_in_ready),
        .avm_wr_address(avm_wr_address), .avm_wr_write(avm_wr_write),
        .avm_wr_writedata(avm_wr_writedata), .avm_wr_waitrequest(avm_wr_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_t;

    int n_checks = 0;
    int n_errors = 0;

    // model configuration
    int rd_lat        = 1;
    int rd_max_accept = 1000;
    bit rd_rand_wait  = 1'b0;
    int out_mode      = 0;      // 0 ready, 1 ready from release_cyc, 2 random
    int release_cyc   = 0;
    int wr_stall      = 0;
    bit in_rand       = 1'b0;

    // model state and logs
    int          cyc = 0;
    int          start_cyc, done_cyc, done_cnt;
    int          rd_accepts, pushes_sent, first_rd_cyc, first_pop_cyc;
    int          last_pop_cyc, last_wr_cyc, wr_stall_cnt;
    bit          rd_prev_stalled, wr_prev_stalled;
    logic [31:0] rd_prev_addr, wr_prev_addr, wr_prev_data;
    ret_t        ret_q[$];
    logic [31:0] rd_log[$];
    int          rd_cyc_log[$];
    logic [31:0] out_log[$];
    logic [31:0] wa_log[$];
    logic [31:0] wd_log[$];
    logic [31:0] src_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        ret_t        e;
        bit          rd_w;
        bit          in_v;
        logic [31:0] tmp;
        @(negedge clk);
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        // read return channel
        avm_rd_readdatavalid = 1'b0;
        avm_rd_readdata      = 32'h0000_0000;
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            e = ret_q.pop_front();
            avm_rd_readdatavalid = 1'b1;
            avm_rd_readdata      = e.data;
            pushes_sent++;
        end
        // read request channel
        if (rd_prev_stalled) begin
            check("rd_hold_read", {31'h0, avm_rd_read}, 32'd1);
            check("rd_hold_addr", avm_rd_address, rd_prev_addr);
        end
        rd_w = (rd_accepts >= rd_max_accept) || (rd_rand_wait && $urandom_range(0, 3) == 0);
        avm_rd_waitrequest = rd_w;
        rd_prev_stalled    = (avm_rd_read === 1'b1) && rd_w;
        rd_prev_addr       = avm_rd_address;
        if (avm_rd_read === 1'b1 && !rd_w) begin
            rd_log.push_back(avm_rd_address);
            rd_cyc_log.push_back(cyc);
            if (rd_accepts == 0) first_rd_cyc = cyc;
            rd_accepts++;
            e.due  = cyc + rd_lat;
            e.data = avm_rd_address ^ 32'hA5A5_A5A5;
            ret_q.push_back(e);
        end
        // stream consumer
        case (out_mode)
            0:       st_out_ready = 1'b1;
            1:       st_out_ready = (cyc >= release_cyc);
            2:       st_out_ready = ($urandom_range(0, 1) == 1);
            default: st_out_ready = 1'b1;
        endcase
        if (st_out_valid === 1'b1 && st_out_ready) begin
            out_log.push_back(st_out_data);
            if (out_log.size() == 1) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
        // write slave
        if (avm_wr_write === 1'b1) begin
            check("wr_in_ready_low", {31'h0, st_in_ready}, 32'd0);
            if (wr_prev_stalled) begin
                check("wr_hold_addr", avm_wr_address, wr_prev_addr);
                check("wr_hold_data", avm_wr_writedata, wr_prev_data);
            end
            if (wr_stall_cnt < wr_stall) begin
                avm_wr_waitrequest = 1'b1;
                wr_stall_cnt++;
                wr_prev_stalled = 1'b1;
            end else begin
                avm_wr_waitrequest = 1'b0;
                wr_stall_cnt    = 0;
                wr_prev_stalled = 1'b0;
                wa_log.push_back(avm_wr_address);
                wd_log.push_back(avm_wr_writedata);
                last_wr_cyc = cyc;
            end
            wr_prev_addr = avm_wr_address;
            wr_prev_data = avm_wr_writedata;
        end else begin
            avm_wr_waitrequest = 1'b0;
            wr_prev_stalled    = 1'b0;
        end
        // stream producer
        in_v        = (src_q.size() > 0) && (!in_rand || $urandom_range(0, 1) == 1);
        st_in_valid = in_v;
        st_in_data  = in_v ? src_q[0] : 32'h0000_0000;
        if (in_v && st_in_ready === 1'b1) tmp = src_q.pop_front();
    endtask

    task automatic start_job(input logic [31:0] sa, input logic [31:0] da,
                             input logic [31:0] rw, input logic [31:0] ww);
        rd_log.delete(); rd_cyc_log.delete(); out_log.delete();
        wa_log.delete(); wd_log.delete();
        done_cnt = 0; rd_accepts = 0; pushes_sent = 0;
        first_rd_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1; last_wr_cyc = -1;
        wr_stall_cnt = 0;
        src_addr = sa; dst_addr = da; rd_words = rw; wr_words = ww;
        start     = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        check("done_seen", {31'h0, (done_cnt != 0)}, 32'd1);
        repeat (3) step();
        check("done_once", done_cnt, 32'd1);
        check("busy_after", {31'h0, busy}, 32'd0);
    endtask

    task automatic verify_reads(input logic [31:0] base, input int n);
        logic [31:0] a;
        check("rd_count", rd_log.size(), n);
        check("out_count", out_log.size(), n);
        for (int i = 0; i < n; i++) begin
            a = base + 32'(4 * i);
            if (i < rd_log.size())  check($sformatf("rd_addr%0d", i), rd_log[i], a);
            if (i < out_log.size()) check($sformatf("out_data%0d", i), out_log[i], a ^ 32'hA5A5_A5A5);
        end
    endtask

    task automatic check_outputs_zero();
        check("zero_busy",    {31'h0, busy},          32'd0);
        check("zero_done",    {31'h0, done},          32'd0);
        check("zero_rd_read", {31'h0, avm_rd_read},   32'd0);
        check("zero_rd_addr", avm_rd_address,         32'd0);
        check("zero_out_vld", {31'h0, st_out_valid},  32'd0);
        check("zero_out_dat", st_out_data,            32'd0);
        check("zero_in_rdy",  {31'h0, st_in_ready},   32'd0);
        check("zero_wr_wr",   {31'h0, avm_wr_write},  32'd0);
        check("zero_wr_addr", avm_wr_address,         32'd0);
        check("zero_wr_data", avm_wr_writedata,       32'd0);
    endtask

    initial begin
        int cnt;
        int n;
        rst_n = 1'b0; start = 1'b0;
        src_addr = 32'h0; dst_addr = 32'h0; rd_words = 32'h0; wr_words = 32'h0;
        avm_rd_waitrequest = 1'b0; avm_rd_readdata = 32'h0; avm_rd_readdatavalid = 1'b0;
        st_out_ready = 1'b0; st_in_data = 32'h0; st_in_valid = 1'b0; avm_wr_waitrequest = 1'b0;
        #12;
        check_outputs_zero();
        step(); step();
        rst_n = 1'b1;
        step();

        // read only, zero-wait memory
        start_job(32'h0000_1000, 32'h0, 32'd4, 32'd0);
        wait_done(100);
        verify_reads(32'h0000_1000, 4);
        check("rd_first_lat", first_rd_cyc - start_cyc, 32'd1);
        check("out_first_lat", first_pop_cyc - first_rd_cyc, 32'd2);
        check("done_lat", done_cyc - start_cyc, 32'd8);

        // backpressure: consumer stalled 40 cycles
        out_mode    = 1;
        release_cyc = cyc + 41;
        start_job(32'h0000_1000, 32'h0, 32'd20, 32'd0);
        wait_done(300);
        verify_reads(32'h0000_1000, 20);
        cnt = 0;
        foreach (rd_cyc_log[i]) if (rd_cyc_log[i] < release_cyc) cnt++;
        check("bp_reads_held", cnt, 32'd8);
        if (rd_cyc_log.size() > 8) check("bp_resume_cyc", rd_cyc_log[8], release_cyc + 1);
        out_mode = 0;

        // write with 5-cycle waitrequest per word, one excess stream word
        wr_stall = 5;
        src_q = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
        start_job(32'h0, 32'h0000_2003, 32'd0, 32'd3);
        wait_done(200);
        check("wr_count", wa_log.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < wa_log.size()) begin
                check($sformatf("wr_addr%0d", i), wa_log[i], 32'h0000_2000 + 32'(4 * i));
                check($sformatf("wr_data%0d", i), wd_log[i], 32'hA000_0001 + 32'(i));
            end
        end
        check("wr_excess_left", src_q.size(), 32'd1);
        check("in_ready_idle", {31'h0, st_in_ready}, 32'd0);
        src_q.delete();
        wr_stall = 0;

        // concurrent job, 3-cycle read latency, random handshakes
        rd_lat = 3; rd_rand_wait = 1'b1; out_mode = 2; in_rand = 1'b1; wr_stall = 2;
        src_q = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000};
        start_job(32'h0000_3000, 32'h0000_4000, 32'd8, 32'd2);
        wait_done(400);
        verify_reads(32'h0000_3000, 8);
        check("cc_wr_count", wa_log.size(), 32'd2);
        if (wa_log.size() == 2) begin
            check("cc_wr_addr1", wa_log[1], 32'h0000_4004);
            check("cc_wr_data1", wd_log[1], 32'h2222_0000);
        end
        check("cc_done_after_wr", {31'h0, (done_cyc >= last_wr_cyc + 2)}, 32'd1);
        check("cc_done_after_pop", {31'h0, (done_cyc >= last_pop_cyc + 2)}, 32'd1);
        src_q.delete();
        rd_lat = 1; rd_rand_wait = 1'b0; out_mode = 0; in_rand = 1'b0; wr_stall = 0;

        // address wrap
        start_job(32'hFFFF_FFF8, 32'h0, 32'd3, 32'd0);
        wait_done(100);
        verify_reads(32'hFFFF_FFF8, 3);

        // both counts zero
        start_job(32'h0, 32'h0, 32'd0, 32'd0);
        check("zero_job_busy", {31'h0, busy}, 32'd1);
        wait_done(20);
        check("zero_job_done_lat", done_cyc - start_cyc, 32'd2);

        // reset mid-job with 2 reads outstanding and 4 words buffered
        rd_lat = 3; rd_max_accept = 6; out_mode = 1; release_cyc = 32'h3FFF_FFFF;
        start_job(32'h0000_5000, 32'h0, 32'd16, 32'd0);
        n = 0;
        while (pushes_sent < 4 && n < 50) begin
            step();
            n++;
        end
        @(posedge clk);
        #1;
        check("rst_pre_valid", {31'h0, st_out_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero();
        ret_q.delete();
        avm_rd_readdatavalid = 1'b0;
        rd_prev_stalled = 1'b0;
        done_cnt = 0;
        repeat (3) step();
        check("rst_no_done", done_cnt, 32'd0);
        rst_n = 1'b1;
        rd_lat = 1; rd_max_accept = 1000; out_mode = 0;
        step();
        start_job(32'h0000_6000, 32'h0, 32'd4, 32'd0);
        wait_done(100);
        verify_reads(32'h0000_6000, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
